// File: rtl/adc_capture_bank.sv
// Multi-channel serial ADC capture bank: steers a shared serial bit line into
// per-channel shift registers, latches completed words and flags frame completion.
module adc_capture_bank #(
  parameter int NUM_CH    = 8,
  parameter int BITS      = 10,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        arm_mask,
  input  logic                     bit_in,
  input  logic [NUM_CH-1:0]        ch_sel,
  output logic [NUM_CH*BITS-1:0]   out_data,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     frame_valid,
  output logic                     busy,
  output logic                     sel_err
);

  localparam int CNT_W = $clog2(BITS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BITS - 1);
  localparam logic [NUM_CH-1:0] SEL_ONE  = NUM_CH'(1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] armed;
  logic [BITS-1:0]   shreg [NUM_CH];
  logic [CNT_W-1:0]  cnt   [NUM_CH];

  logic              arm_req;
  logic              capturing;
  logic              sel_any;
  logic              sel_onehot;
  logic              sel_multi;
  logic [NUM_CH-1:0] shift_vec;
  logic [NUM_CH-1:0] newly_done;
  logic              frame_done;

  function automatic logic [BITS-1:0] shift_in(input logic [BITS-1:0] s,
                                               input logic b);
    if (MSB_FIRST != 0) shift_in = {s[BITS-2:0], b};
    else                shift_in = {b, s[BITS-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm_req) state_nxt = CAPTURE;
      CAPTURE: if (arm_req)         state_nxt = CAPTURE;
               else if (frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A re-arm request outranks any shift decoded in the same cycle.
  always_comb begin
    busy       = (state == CAPTURE);
    arm_req    = start && (arm_mask != '0);
    capturing  = busy && !arm_req;
    sel_any    = (ch_sel != '0);
    sel_onehot = sel_any && ((ch_sel & (ch_sel - SEL_ONE)) == '0);
    sel_multi  = capturing && sel_any && !sel_onehot;
    shift_vec  = (capturing && sel_onehot) ? (ch_sel & armed & ~ch_done) : '0;
    for (int i = 0; i < NUM_CH; i++)
      newly_done[i] = shift_vec[i] && (cnt[i] == CNT_LAST);
    frame_done = capturing && (((ch_done | newly_done) & armed) == armed);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed       <= '0;
      ch_done     <= '0;
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
      out_data    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shreg[i] <= '0;
        cnt[i]   <= '0;
      end
    end else if (arm_req) begin
      armed       <= arm_mask;
      ch_done     <= '0;
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shreg[i] <= '0;
        cnt[i]   <= '0;
      end
    end else begin
      frame_valid <= frame_done;
      if (sel_multi) sel_err <= 1'b1;
      ch_done <= ch_done | newly_done;
      for (int i = 0; i < NUM_CH; i++) begin
        if (shift_vec[i]) begin
          shreg[i] <= shift_in(shreg[i], bit_in);
          cnt[i]   <= cnt[i] + 1'b1;
          if (newly_done[i])
            out_data[i*BITS +: BITS] <= shift_in(shreg[i], bit_in);
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_bank.sv
// Bench for adc_capture_bank: MSB-first and LSB-first instances share one stimulus
// stream and are compared each cycle against a queue-based frame model.
module tb_adc_capture_bank;

  localparam int NUM_CH = 8;
  localparam int BITS   = 10;
  localparam int OW     = NUM_CH * BITS;

  logic              clk = 1'b0;
  logic              reset, start, bit_in;
  logic [NUM_CH-1:0] arm_mask, ch_sel;

  logic [OW-1:0]     out_m, out_l;
  logic [NUM_CH-1:0] done_m, done_l;
  logic              fv_m, fv_l, busy_m, busy_l, err_m, err_l;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adc_capture_bank #(.NUM_CH(NUM_CH), .BITS(BITS), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .start(start), .arm_mask(arm_mask),
    .bit_in(bit_in), .ch_sel(ch_sel), .out_data(out_m), .ch_done(done_m),
    .frame_valid(fv_m), .busy(busy_m), .sel_err(err_m));

  adc_capture_bank #(.NUM_CH(NUM_CH), .BITS(BITS), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .start(start), .arm_mask(arm_mask),
    .bit_in(bit_in), .ch_sel(ch_sel), .out_data(out_l), .ch_done(done_l),
    .frame_valid(fv_l), .busy(busy_l), .sel_err(err_l));

  // Reference model: per-channel lists of received bits, words formed on completion.
  bit                m_q [NUM_CH][$];
  logic [BITS-1:0]   m_word_m [NUM_CH];
  logic [BITS-1:0]   m_word_l [NUM_CH];
  logic [NUM_CH-1:0] m_armed, m_done;
  logic              m_busy, m_fv, m_err;

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear_frame();
    for (int c = 0; c < NUM_CH; c++) m_q[c].delete();
    m_done = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_reset();
    model_clear_frame();
    for (int c = 0; c < NUM_CH; c++) begin
      m_word_m[c] = '0;
      m_word_l[c] = '0;
    end
    m_armed = '0;
    m_busy  = 1'b0;
    m_fv    = 1'b0;
  endtask

  task automatic model_edge();
    int nset, ch;
    logic [BITS-1:0] wm, wl;
    if (reset) begin
      model_reset();
      return;
    end
    m_fv = 1'b0;
    if (start && arm_mask != '0) begin
      m_armed = arm_mask;
      model_clear_frame();
      m_busy = 1'b1;
    end else if (m_busy) begin
      nset = $countones(ch_sel);
      ch = 0;
      for (int c = 0; c < NUM_CH; c++) if (ch_sel[c]) ch = c;
      if (nset > 1) m_err = 1'b1;
      else if (nset == 1 && m_armed[ch] && !m_done[ch]) begin
        m_q[ch].push_back(bit_in);
        if (m_q[ch].size() == BITS) begin
          wm = '0;
          wl = '0;
          for (int k = 0; k < BITS; k++) begin
            wm = (wm << 1) | BITS'(m_q[ch][k]);
            wl = wl | (BITS'(m_q[ch][k]) << k);
          end
          m_word_m[ch] = wm;
          m_word_l[ch] = wl;
          m_done[ch] = 1'b1;
          if ((m_done & m_armed) == m_armed) begin
            m_fv   = 1'b1;
            m_busy = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [OW-1:0] em, el;
    for (int c = 0; c < NUM_CH; c++) begin
      em[c*BITS +: BITS] = m_word_m[c];
      el[c*BITS +: BITS] = m_word_l[c];
    end
    chk("out_msb",  out_m, em);
    chk("out_lsb",  out_l, el);
    chk("done_msb", OW'(done_m), OW'(m_done));
    chk("done_lsb", OW'(done_l), OW'(m_done));
    chk("fv_msb",   OW'(fv_m),   OW'(m_fv));
    chk("fv_lsb",   OW'(fv_l),   OW'(m_fv));
    chk("busy_msb", OW'(busy_m), OW'(m_busy));
    chk("busy_lsb", OW'(busy_l), OW'(m_busy));
    chk("err_msb",  OW'(err_m),  OW'(m_err));
    chk("err_lsb",  OW'(err_l),  OW'(m_err));
  endtask

  task automatic step(input logic r, input logic s, input logic [NUM_CH-1:0] m,
                      input logic b, input logic [NUM_CH-1:0] sel);
    @(negedge clk);
    reset = r; start = s; arm_mask = m; bit_in = b; ch_sel = sel;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(); step(1'b0, 1'b0, '0, 1'b0, '0); endtask
  task automatic arm(input logic [NUM_CH-1:0] m); step(1'b0, 1'b1, m, 1'b0, '0); endtask

  task automatic feed_word(input int ch, input logic [BITS-1:0] w, input int nbits);
    for (int k = 0; k < nbits; k++)
      step(1'b0, 1'b0, '0, w[BITS-1-k], NUM_CH'(1) << ch);
  endtask

  logic [BITS-1:0] w0, w7;

  initial begin
    reset = 1'b1; start = 1'b0; arm_mask = '0; bit_in = 1'b0; ch_sel = '0;
    model_reset();
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    chk("reset_out", out_m, '0);

    // Default stream: 1,1,0,0,0,0,0,0,0,1 on channel 0.
    arm(8'h01);
    feed_word(0, 10'b1100000001, BITS);
    chk("t1_word_msb", OW'(out_m[9:0]), OW'(10'h301));
    chk("t1_word_lsb", OW'(out_l[9:0]), OW'(10'h203));
    chk("t1_fv", OW'(fv_m), OW'(1'b1));
    idle();
    chk("t1_fv_once", OW'(fv_m), OW'(1'b0));

    // Interleaved ch0/ch7 with idle gaps.
    arm(8'h81);
    w0 = 10'h155; w7 = 10'h2AA;
    for (int k = 0; k < BITS; k++) begin
      step(1'b0, 1'b0, '0, w0[BITS-1-k], 8'h01);
      idle();
      if (k == BITS - 1) begin
        chk("t3_done_ch0", OW'(done_m), OW'(8'h01));
        chk("t3_fv_early", OW'(fv_m), OW'(1'b0));
      end
      step(1'b0, 1'b0, '0, w7[BITS-1-k], 8'h80);
    end
    chk("t3_word7", OW'(out_m[79:70]), OW'(10'h2AA));
    chk("t3_fv", OW'(fv_m), OW'(1'b1));

    // Multi-hot select mid-frame.
    arm(8'h03);
    feed_word(0, 10'h3C5, 3);
    step(1'b0, 1'b0, '0, 1'b1, 8'h03);
    chk("t4_err", OW'(err_m), OW'(1'b1));
    step(1'b0, 1'b0, '0, 1'b0, 8'h03);
    feed_word(0, 10'h3C5 << 3, BITS - 3);
    feed_word(1, 10'h0F3, BITS);
    chk("t4_fv", OW'(fv_m), OW'(1'b1));
    chk("t4_word0", OW'(out_m[9:0]), OW'(10'h3C5));
    idle();
    chk("t4_err_hold", OW'(err_m), OW'(1'b1));
    arm(8'h01);
    chk("t4_err_clr", OW'(err_m), OW'(1'b0));

    // Abort keeps held words.
    feed_word(0, 10'h301, BITS);
    arm(8'h01);
    feed_word(0, 10'h0AB, 5);
    arm(8'h01);
    chk("t5_hold", OW'(out_m[9:0]), OW'(10'h301));
    feed_word(0, 10'h0AB, BITS);
    chk("t5_word", OW'(out_m[9:0]), OW'(10'h0AB));

    // Reset mid-capture, then stray select activity.
    arm(8'h01);
    feed_word(0, 10'h3FF, 4);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    chk("t6_out", out_m, '0);
    chk("t6_busy", OW'(busy_m), OW'(1'b0));
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, '0, 1'b1, 8'h01);
    chk("t6_ignored", OW'(done_m), OW'(8'h00));

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [NUM_CH-1:0] m, sel;
      r = $urandom_range(0, 999);
      m = (NUM_CH'(1) << $urandom_range(0, NUM_CH - 1)) |
          (NUM_CH'(1) << $urandom_range(0, NUM_CH - 1));
      if (r < 3) step(1'b1, 1'b0, '0, 1'b0, '0);
      else if (r < 8) step(1'b0, 1'b1, '0, 1'($urandom), '0);
      else if (r < 15) step(1'b0, 1'b1, m, 1'($urandom), 8'h01);
      else begin
        r = $urandom_range(0, 99);
        if (r < 15) sel = '0;
        else if (r < 18) sel = NUM_CH'($urandom) | 8'h11;
        else if (r < 50) sel = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
        else begin
          sel = '0;
          for (int t = 0; t < 8 && sel == '0; t++) begin
            sel = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
            if ((sel & m_armed & ~m_done) == '0 && t < 7) sel = '0;
          end
        end
        step(1'b0, 1'b0, '0, 1'($urandom), sel);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
